// File: rtl/poly_tone_gen.sv
`timescale 1ns/1ps
// poly_tone_gen: maps a held-key bitmap onto a pool of square-wave voices,
// mixes the active voices and delta-sigma modulates the mix onto one pin.
// Everything runs on sysclk; audio timing comes from a tick enable.
module poly_tone_gen #(
    parameter int NUM_KEYS   = 13,
    parameter int NUM_VOICES = 4,
    parameter int BASE_NOTE  = 25,
    parameter int CLK_DIV    = 4
) (
    input  logic                             sysclk,
    input  logic                             rst,
    input  logic [NUM_KEYS-1:0]              keys,
    input  logic [1:0]                       octave_shift,
    input  logic                             mute,
    output logic                             speaker,
    output logic [NUM_VOICES-1:0]            voice_active,
    output logic [$clog2(NUM_VOICES+1)-1:0]  mix_level
);

    localparam int KW = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int MW = $clog2(NUM_VOICES + 1);
    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [KW-1:0]         LAST_IDX = KW'(NUM_KEYS - 1);
    localparam logic [TW-1:0]         LAST_TCK = TW'(CLK_DIV - 1);
    localparam logic [MW:0]           NV_W     = (MW+1)'(NUM_VOICES);
    localparam logic [NUM_VOICES-1:0] ONE_V    = NUM_VOICES'(1);

    // Split a 6-bit note code into {octave[2:0], semitone[3:0]}.
    function automatic logic [6:0] note_split(input logic [5:0] n);
        logic [2:0] o;
        logic [3:0] s;
        if (n >= 6'd60) begin
            o = 3'd5; s = 4'(n - 6'd60);
        end else if (n >= 6'd48) begin
            o = 3'd4; s = 4'(n - 6'd48);
        end else if (n >= 6'd36) begin
            o = 3'd3; s = 4'(n - 6'd36);
        end else if (n >= 6'd24) begin
            o = 3'd2; s = 4'(n - 6'd24);
        end else if (n >= 6'd12) begin
            o = 3'd1; s = 4'(n - 6'd12);
        end else begin
            o = 3'd0; s = 4'(n);
        end
        return {o, s};
    endfunction

    // Semitone divider: reload value of the 9-bit note counter (s = 0 is A).
    function automatic logic [8:0] semi_div(input logic [3:0] s);
        case (s)
            4'd0:    return 9'd511;
            4'd1:    return 9'd482;
            4'd2:    return 9'd455;
            4'd3:    return 9'd430;
            4'd4:    return 9'd405;
            4'd5:    return 9'd383;
            4'd6:    return 9'd361;
            4'd7:    return 9'd341;
            4'd8:    return 9'd322;
            4'd9:    return 9'd303;
            4'd10:   return 9'd286;
            default: return 9'd270;
        endcase
    endfunction

    // Octave reload: (256 >> min(o,5)) - 1, saturating the octave at 5.
    function automatic logic [7:0] oct_reload(input logic [2:0] o);
        logic [2:0] oc;
        oc = (o > 3'd5) ? 3'd5 : o;
        return 8'((9'd256 >> oc) - 9'd1);
    endfunction

    typedef enum logic {SNAP, SCAN} state_t;

    logic [TW-1:0]         tick_cnt;
    logic                  tick;
    state_t                state_q, state_d;
    logic                  do_snap, do_scan;
    logic [NUM_KEYS-1:0]   snap, held;
    logic [1:0]            shift_q;
    logic [KW-1:0]         idx;
    logic [7:0]            note_n;
    logic                  note_ok;
    logic [6:0]            note_os;
    logic [8:0]            alloc_d;
    logic [7:0]            alloc_r;
    logic                  free_any;
    logic [VW-1:0]         free_idx;
    logic [NUM_VOICES-1:0] rel_hit, alloc_vec, free_vec;
    logic                  key_press, key_rel;

    logic [KW-1:0]         key_id   [NUM_VOICES];
    logic [8:0]            div_d    [NUM_VOICES];
    logic [7:0]            div_r    [NUM_VOICES];
    logic [8:0]            cnt_note [NUM_VOICES];
    logic [7:0]            cnt_oct  [NUM_VOICES];
    logic [NUM_VOICES-1:0] sq;

    logic [MW-1:0]         mix_sum;
    logic [MW-1:0]         acc;
    logic [MW:0]           ds_sum;

    // Free-running tick divider.
    always_ff @(posedge sysclk) begin
        if (rst || tick) tick_cnt <= '0;
        else             tick_cnt <= tick_cnt + TW'(1);
    end
    assign tick = (tick_cnt == LAST_TCK);

    // Scanner state register.
    always_ff @(posedge sysclk) begin
        if (rst) state_q <= SNAP;
        else     state_q <= state_d;
    end

    // Scanner next state: one snapshot cycle, then one cycle per key.
    always_comb begin
        state_d = state_q;
        case (state_q)
            SNAP:    state_d = SCAN;
            SCAN:    if (idx == LAST_IDX) state_d = SNAP;
            default: state_d = SNAP;
        endcase
    end

    // Scanner outputs.
    always_comb begin
        do_snap = (state_q == SNAP);
        do_scan = (state_q == SCAN);
    end

    // Note code of the key under scan, and its divider pair.
    assign note_n  = 8'(BASE_NOTE) + 8'(idx) + 8'(shift_q) * 8'd12;
    assign note_ok = (note_n <= 8'd63);
    assign note_os = note_split(note_n[5:0]);
    assign alloc_d = semi_div(note_os[3:0]);
    assign alloc_r = oct_reload(note_os[6:4]);

    // Lowest-numbered free voice.
    always_comb begin
        free_any = 1'b0;
        free_idx = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_active[v]) begin
                free_any = 1'b1;
                free_idx = VW'(v);
            end
        end
    end

    // Voice currently owned by the key under scan.
    always_comb begin
        rel_hit = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            rel_hit[v] = voice_active[v] && (key_id[v] == idx);
    end

    assign key_press = do_scan && snap[idx] && !held[idx] && note_ok && free_any;
    assign key_rel   = do_scan && !snap[idx] && held[idx];
    assign alloc_vec = key_press ? (ONE_V << free_idx) : '0;
    assign free_vec  = key_rel ? rel_hit : '0;

    // Scan index and per-key held flags.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            idx  <= '0;
            held <= '0;
        end else begin
            if (do_snap)      idx <= '0;
            else if (do_scan) idx <= idx + KW'(1);
            if (key_press)    held[idx] <= 1'b1;
            else if (key_rel) held[idx] <= 1'b0;
        end
    end

    // Keyboard and octave snapshot taken once per scan.
    always_ff @(posedge sysclk) begin
        if (do_snap) begin
            snap    <= keys;
            shift_q <= octave_shift;
        end
    end

    // Voice allocation state and square outputs.
    always_ff @(posedge sysclk) begin
        if (rst) begin
            voice_active <= '0;
            sq           <= '0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (alloc_vec[v]) begin
                    voice_active[v] <= 1'b1;
                    sq[v]           <= 1'b0;
                end else if (free_vec[v]) begin
                    voice_active[v] <= 1'b0;
                    sq[v]           <= 1'b0;
                end else if (voice_active[v] && tick &&
                             cnt_note[v] == 9'd0 && cnt_oct[v] == 8'd0) begin
                    sq[v] <= ~sq[v];
                end
            end
        end
    end

    // Voice dividers: load on allocation, count on ticks while allocated.
    always_ff @(posedge sysclk) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (alloc_vec[v]) begin
                key_id[v]   <= idx;
                div_d[v]    <= alloc_d;
                div_r[v]    <= alloc_r;
                cnt_note[v] <= '0;
                cnt_oct[v]  <= '0;
            end else if (voice_active[v] && tick) begin
                if (cnt_note[v] == 9'd0) begin
                    cnt_note[v] <= div_d[v];
                    if (cnt_oct[v] == 8'd0) cnt_oct[v] <= div_r[v];
                    else                    cnt_oct[v] <= cnt_oct[v] - 8'd1;
                end else begin
                    cnt_note[v] <= cnt_note[v] - 9'd1;
                end
            end
        end
    end

    // Count of sounding voices whose square is high.
    always_comb begin
        mix_sum = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            mix_sum = mix_sum + MW'(voice_active[v] & sq[v]);
    end

    // Registered mix level.
    always_ff @(posedge sysclk) begin
        if (rst) mix_level <= '0;
        else     mix_level <= mix_sum;
    end

    assign ds_sum = {1'b0, acc} + {1'b0, mix_level};

    // First-order delta-sigma: emit a 1 each time the accumulator wraps NUM_VOICES.
    always_ff @(posedge sysclk) begin
        if (rst || mute) begin
            speaker <= 1'b0;
            acc     <= '0;
        end else if (ds_sum >= NV_W) begin
            speaker <= 1'b1;
            acc     <= MW'(ds_sum - NV_W);
        end else begin
            speaker <= 1'b0;
            acc     <= MW'(ds_sum);
        end
    end

endmodule
